synapse_pe: RTL and testbench

SYNAPSE_PE -- requirements
Module: synapse_pe

---
 rtl/syn_pkg.sv | 31 +++
 rtl/synapse_wmem.sv | 36 +++
 rtl/synapse_pe.sv | 165 ++++++++++++++++
 tb/tb_synapse_pe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/syn_pkg.sv
// ============================================================================
// Module : syn_pkg
// Brief  : Shared types, default sizes and saturation helpers for synapse_pe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package syn_pkg;

  localparam int SYN_DATA_W = 16;
  localparam int SYN_ACC_W  = 40;
  localparam int SYN_DEPTH  = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_OUT   = 2'd3
  } syn_state_e;

  function automatic longint sat_hi(input int data_w);
    return (longint'(1) <<< (data_w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int data_w);
    return -(longint'(1) <<< (data_w - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/synapse_wmem.sv
// ============================================================================
// Module : synapse_wmem
// Brief  : Weight store, one synchronous write port, one asynchronous read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module synapse_wmem
  import syn_pkg::*;
#(
  parameter int  DATA_W = SYN_DATA_W,
  parameter int  DEPTH  = SYN_DEPTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Same-cycle read of a written address sees the old weight.
  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/synapse_pe.sv
// ============================================================================
// Module : synapse_pe
// Brief  : Streaming dot-product processing element with shift/ReLU/saturate.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module synapse_pe
  import syn_pkg::*;
#(
  parameter int  DATA_W = SYN_DATA_W,
  parameter int  ACC_W  = SYN_ACC_W,
  parameter int  DEPTH  = SYN_DEPTH,
  localparam int AW     = $clog2(DEPTH),
  localparam int SW     = $clog2(ACC_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     cfg_len,
  input  logic [SW-1:0]     cfg_shift,
  input  logic              cfg_relu,
  output logic              busy,
  input  logic              w_we,
  input  logic [AW-1:0]     w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              x_valid,
  input  logic [DATA_W-1:0] x_data,
  output logic              x_ready,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_data,
  output logic              y_valid,
  output logic [DATA_W-1:0] y_data,
  input  logic              y_ready
);

  localparam int PW = 2 * DATA_W;

  generate
    if (ACC_W < PW + AW) begin : g_acc_w_check
      $error("synapse_pe: ACC_W too small for DATA_W and DEPTH");
    end
  endgenerate

  localparam logic signed [ACC_W-1:0] c_sat_hi = ACC_W'(sat_hi(DATA_W));
  localparam logic signed [ACC_W-1:0] c_sat_lo = ACC_W'(sat_lo(DATA_W));

  syn_state_e               r_state;
  logic [AW-1:0]            r_cnt;
  logic [AW-1:0]            r_len;
  logic [SW-1:0]            r_shift;
  logic                     r_relu;
  logic signed [PW-1:0]     r_m;
  logic                     r_pend;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_f_valid;
  logic [DATA_W-1:0]        r_f_data;
  logic                     r_y_valid;
  logic [DATA_W-1:0]        r_y_data;

  logic [DATA_W-1:0]        w_rd;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_m_ext;
  logic signed [ACC_W-1:0]  w_acc_final;
  logic signed [ACC_W-1:0]  w_shifted;
  logic signed [ACC_W-1:0]  w_clamped;
  logic [DATA_W-1:0]        w_result;

  synapse_wmem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_wmem (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_addr),
    .wdata (w_data),
    .raddr (r_cnt),
    .rdata (w_rd)
  );

  assign w_prod      = $signed(x_data) * $signed(w_rd);
  assign w_m_ext     = {{(ACC_W-PW){r_m[PW-1]}}, r_m};
  // The product registered on the last accept is still pending in FLUSH.
  assign w_acc_final = r_pend ? (r_acc + w_m_ext) : r_acc;
  assign w_shifted   = w_acc_final >>> r_shift;
  assign w_clamped   = (r_relu && w_shifted[ACC_W-1]) ? '0 : w_shifted;

  always_comb begin
    w_result = w_clamped[DATA_W-1:0];
    if (w_clamped > c_sat_hi) begin
      w_result = c_sat_hi[DATA_W-1:0];
    end else if (w_clamped < c_sat_lo) begin
      w_result = c_sat_lo[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_len     <= '0;
      r_shift   <= '0;
      r_relu    <= 1'b0;
      r_m       <= '0;
      r_pend    <= 1'b0;
      r_acc     <= '0;
      r_f_valid <= 1'b0;
      r_f_data  <= '0;
      r_y_valid <= 1'b0;
      r_y_data  <= '0;
    end else begin
      r_f_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_pend  <= 1'b0;
            r_len   <= cfg_len;
            r_shift <= cfg_shift;
            r_relu  <= cfg_relu;
          end
        end
        ST_RUN: begin
          if (x_valid) begin
            r_m       <= w_prod;
            r_pend    <= 1'b1;
            r_acc     <= w_acc_final;
            r_cnt     <= r_cnt + 1'b1;
            r_f_data  <= x_data;
            r_f_valid <= 1'b1;
            if (r_cnt == r_len) begin
              r_state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          r_acc     <= w_acc_final;
          r_pend    <= 1'b0;
          r_y_data  <= w_result;
          r_y_valid <= 1'b1;
          r_state   <= ST_OUT;
        end
        ST_OUT: begin
          if (y_ready) begin
            r_y_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign x_ready = (r_state == ST_RUN);
  assign f_valid = r_f_valid;
  assign f_data  = r_f_data;
  assign y_valid = r_y_valid;
  assign y_data  = r_y_data;

endmodule

`default_nettype wire

// File: tb/tb_synapse_pe.sv
// ============================================================================
// Module : tb_synapse_pe
// Brief  : Randomized and directed self-checking bench for synapse_pe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_synapse_pe;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  cfg_len;
  logic [5:0]  cfg_shift;
  logic        cfg_relu;
  logic        busy;
  logic        w_we;
  logic [5:0]  w_addr;
  logic [15:0] w_data;
  logic        x_valid;
  logic [15:0] x_data;
  logic        x_ready;
  logic        f_valid;
  logic [15:0] f_data;
  logic        y_valid;
  logic [15:0] y_data;
  logic        y_ready;

  synapse_pe dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .busy      (busy),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .x_valid   (x_valid),
    .x_data    (x_data),
    .x_ready   (x_ready),
    .f_valid   (f_valid),
    .f_data    (f_data),
    .y_valid   (y_valid),
    .y_data    (y_data),
    .y_ready   (y_ready)
  );

  always #5 clk = ~clk;

  int     n_chk  = 0;
  int     n_fail = 0;
  int     wm [64];
  int     tx_x [64];
  longint exp_q [$];
  longint last_y;
  int     f_pulses;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int addr, input int val);
    w_we   = 1'b1;
    w_addr = 6'(addr);
    w_data = 16'(val);
    step();
    w_we   = 1'b0;
    wm[addr] = val;
  endtask

  // Reference: plain signed sum of products, then shift, ReLU, saturate.
  function automatic longint model_y(input int len, input int shift, input bit relu);
    longint s = 0;
    for (int i = 0; i <= len; i++) s += longint'(tx_x[i]) * longint'(wm[i]);
    s = s >>> shift;
    if (relu && s < 0) s = 0;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  // Transaction-level model of the PE, advanced once per cycle.
  bit              in_txn, out_phase, prev_acc, exp_ready, start_ok;
  int              accepts, m_len, flush_cd;
  logic signed [15:0] prev_x;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_x_ready", x_ready, 0);
      chk("rst_f_valid", f_valid, 0);
      chk("rst_f_data", f_data, 0);
      chk("rst_y_valid", y_valid, 0);
      chk("rst_y_data", y_data, 0);
      in_txn = 0; out_phase = 0; prev_acc = 0; accepts = 0; flush_cd = -1;
      exp_q.delete();
    end else begin
      if (flush_cd > 0) begin
        flush_cd--;
        if (flush_cd == 0) begin
          out_phase = 1;
          flush_cd  = -1;
        end
      end
      exp_ready = in_txn && !out_phase && (accepts <= m_len);
      chk("busy", busy, in_txn);
      chk("x_ready", x_ready, exp_ready);
      chk("f_valid", f_valid, prev_acc);
      if (prev_acc) chk("f_data", longint'($signed(f_data)), longint'(prev_x));
      chk("y_valid", y_valid, out_phase);
      if (out_phase && y_valid) begin
        if (exp_q.size() == 0) chk("y_expect_q", 0, 1);
        else chk("y_data", longint'($signed(y_data)), exp_q[0]);
      end
      if (f_valid) f_pulses++;
      start_ok = !in_txn && start;
      prev_acc = x_valid && exp_ready;
      prev_x   = x_data;
      if (prev_acc) begin
        accepts++;
        if (accepts == m_len + 1) flush_cd = 2;
      end
      if (out_phase && y_valid && y_ready) begin
        last_y = longint'($signed(y_data));
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        out_phase = 0;
        in_txn    = 0;
      end
      if (start_ok) begin
        in_txn  = 1;
        accepts = 0;
        m_len   = int'(cfg_len);
      end
    end
  end

  // gap: 0 none, 1 alternate cycles, 2 random
  task automatic run_txn(input int len, input int shift, input bit relu,
                         input int gap, input int rdly, input bit start_in_out);
    int t;
    exp_q.push_back(model_y(len, shift, relu));
    start = 1'b1; cfg_len = 6'(len); cfg_shift = 6'(shift); cfg_relu = relu;
    step();
    start = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (gap == 1) begin
        x_valid = 1'b0; x_data = 16'($urandom); step();
      end else if (gap == 2) begin
        while ($urandom_range(0, 2) == 0) begin
          x_valid = 1'b0; x_data = 16'($urandom); step();
        end
      end
      x_valid = 1'b1;
      x_data  = 16'(tx_x[i]);
      step();
    end
    x_valid = 1'b0;
    t = 0;
    while (!y_valid && t < 20) begin
      step();
      t++;
    end
    if (!y_valid) chk("y_timeout", 0, 1);
    for (int i = 0; i < rdly; i++) begin
      if (start_in_out) begin
        chk("out_busy", busy, 1);
        start = (i == 2);
      end
      step();
    end
    start   = 1'b0;
    y_ready = 1'b1;
    step();
    y_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; cfg_len = '0; cfg_shift = '0; cfg_relu = 1'b0;
    w_we = 1'b0; w_addr = '0; w_data = '0; x_valid = 1'b0; x_data = '0;
    y_ready = 1'b0; f_pulses = 0; last_y = 0;
    repeat (3) step();
    rst = 1'b1;
    step();

    // Basic dot product and forwarding
    write_w(0, 1); write_w(1, 2); write_w(2, 3); write_w(3, 4);
    for (int i = 0; i < 4; i++) tx_x[i] = 1;
    f_pulses = 0;
    run_txn(3, 0, 0, 0, 0, 0);
    chk("y_basic", last_y, 10);
    chk("f_pulses", f_pulses, 4);

    // Saturation at both ends
    for (int i = 0; i < 4; i++) write_w(i, 32767);
    for (int i = 0; i < 4; i++) tx_x[i] = 32767;
    run_txn(3, 0, 0, 0, 0, 0);
    chk("y_sat_hi", last_y, 32767);
    for (int i = 0; i < 4; i++) tx_x[i] = -32768;
    run_txn(3, 0, 0, 0, 0, 0);
    chk("y_sat_lo", last_y, -32768);

    // ReLU
    write_w(0, -5);
    tx_x[0] = 3;
    run_txn(0, 0, 0, 0, 0, 0);
    chk("y_neg", last_y, -15);
    run_txn(0, 0, 1, 0, 0, 0);
    chk("y_relu", last_y, 0);

    // Shift, with and without input gaps
    write_w(0, 16);
    tx_x[0] = 16;
    run_txn(0, 4, 0, 0, 0, 0);
    chk("y_shift", last_y, 16);
    run_txn(0, 4, 0, 1, 0, 0);
    chk("y_shift_gap", last_y, 16);

    // Output back-pressure with an ignored start
    run_txn(0, 4, 0, 0, 5, 1);
    chk("y_hold", last_y, 16);
    chk("idle_after_hs", busy, 0);

    // Reset in the middle of a run
    write_w(0, 1); write_w(1, 2); write_w(2, 3); write_w(3, 4);
    start = 1'b1; cfg_len = 6'd3; cfg_shift = '0; cfg_relu = 1'b0;
    step();
    start = 1'b0;
    x_valid = 1'b1; x_data = 16'd7;
    step(); step();
    x_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_x_ready", x_ready, 0);
    chk("arst_f_valid", f_valid, 0);
    chk("arst_f_data", f_data, 0);
    chk("arst_y_valid", y_valid, 0);
    step(); step();
    rst = 1'b1;
    step();
    write_w(0, 1); write_w(1, 2);
    tx_x[0] = 5; tx_x[1] = 5;
    run_txn(1, 0, 0, 0, 0, 0);
    chk("y_after_rst", last_y, 15);

    // Randomized transactions
    for (int k = 0; k < 25; k++) begin
      int len, big;
      len = (k % 4 == 0) ? int'($urandom_range(16, 63)) : int'($urandom_range(0, 7));
      big = int'($urandom_range(0, 1));
      for (int i = 0; i <= len; i++) begin
        if (big != 0) begin
          write_w(i, int'($urandom_range(0, 65535)) - 32768);
          tx_x[i] = int'($urandom_range(0, 65535)) - 32768;
        end else begin
          write_w(i, int'($urandom_range(0, 200)) - 100);
          tx_x[i] = int'($urandom_range(0, 200)) - 100;
        end
      end
      run_txn(len, int'($urandom_range(0, 24)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0);
    end

    step(); step();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
